// File: rtl/pipe_sched_pkg.sv
// Shared definitions for the host-pipe block scheduler.
//   state_t    : scheduler states (HDR is only reachable with PIPE_FRAME_HDR_EN)
//   HDR_MAGIC  : upper byte of the optional block header word
//   DRAIN_CYC  : cycles spent flushing the two-stage read pipeline after a burst
package pipe_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    READY = 3'd2,
    HDR   = 3'd3,
    BURST = 3'd4,
    DRAIN = 3'd5
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int         DRAIN_CYC = 2;

endpackage

// File: rtl/pipe_sticky_flag.sv
// Sticky status bit with set priority over clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the flag
//   set   : sets the flag (wins over clr in the same cycle)
//   clr   : clears the flag
//   flag  : registered sticky flag
module pipe_sticky_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic flag
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its inputs, independent of
  // process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (set) begin
      flag <= 1'b1;
    end else if (clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_block_scheduler.sv
// Readout controller between the 16-bit output FIFO and the host pipe.
// Waits for a full block in the FIFO, advertises it with blk_ready, and on a
// host_start pulse drains exactly one block as a registered word stream.
// Optional feature macro: PIPE_FRAME_HDR_EN (prepends {A5, seq_num[7:0]}).
//
// Ports:
//   FPGA_CLK, RST_N : clock, asynchronous active-low reset
//   enable          : acquisition run enable (level)
//   fifo_rdcnt      : FIFO words available
//   fifo_empty/full : FIFO status flags
//   fifo_q          : FIFO read data, valid the cycle after fifo_re
//   fifo_re         : FIFO read enable
//   host_start      : one-cycle request for one block (honoured in READY only)
//   clr_flags       : one-cycle clear of the sticky flags
//   blk_ready       : a full block is waiting for host_start
//   busy            : from host_start acceptance through the last pipe word
//   pipe_valid/data : block word stream
//   overflow        : sticky, FIFO was full while enabled
//   underrun        : sticky, FIFO was empty when a read was due
//   seq_num         : completed block count (wraps, reset only by RST_N)
module pipe_block_scheduler
  import pipe_sched_pkg::*;
#(
  parameter int BLOCK_WORDS = 256,
  parameter int CNT_W       = 12
) (
  input  logic             FPGA_CLK,
  input  logic             RST_N,
  input  logic             enable,
  input  logic [CNT_W-1:0] fifo_rdcnt,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic [15:0]      fifo_q,
  output logic             fifo_re,
  input  logic             host_start,
  input  logic             clr_flags,
  output logic             blk_ready,
  output logic             busy,
  output logic             pipe_valid,
  output logic [15:0]      pipe_data,
  output logic             overflow,
  output logic             underrun,
  output logic [15:0]      seq_num
);

  localparam logic [CNT_W-1:0] BLK_CNT    = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rd_cnt;
  logic [1:0]       drain_cnt;
  logic             rd_d1;
  logic             hdr_emit;
  logic             last_read;
  logic             drain_done;

  assign last_read  = (rd_cnt == LAST_IDX);
  assign drain_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
  assign blk_ready  = (state == READY);
  assign busy       = (state == HDR) || (state == BURST) || (state == DRAIN);

`ifdef PIPE_FRAME_HDR_EN
  assign hdr_emit = (state == HDR);
`else
  assign hdr_emit = 1'b0;
`endif

  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    fifo_re   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = WAIT;
      end
      WAIT: begin
        if (!enable)                   state_nxt = IDLE;
        else if (fifo_rdcnt >= BLK_CNT) state_nxt = READY;
      end
      READY: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (host_start) begin
`ifdef PIPE_FRAME_HDR_EN
          state_nxt = HDR;
`else
          state_nxt = BURST;
`endif
        end
      end
`ifdef PIPE_FRAME_HDR_EN
      HDR: begin
        // Header word is produced internally; no FIFO read this cycle.
        state_nxt = BURST;
      end
`endif
      BURST: begin
        // An empty FIFO stalls the burst; enable is ignored so blocks are
        // never truncated.
        fifo_re = !fifo_empty;
        if (fifo_re && last_read) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nxt = enable ? WAIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read pipeline: fifo_re (t) -> fifo_q sampled at end of t+1 -> pipe (t+2).
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_cnt     <= '0;
      drain_cnt  <= '0;
      rd_d1      <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
      seq_num    <= '0;
    end else begin
      if (state == BURST) begin
        if (fifo_re) rd_cnt <= rd_cnt + CNT_W'(1);
      end else begin
        rd_cnt <= '0;
      end

      drain_cnt  <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      rd_d1      <= fifo_re;
      pipe_valid <= rd_d1 | hdr_emit;

      if (hdr_emit) begin
        pipe_data <= {HDR_MAGIC, seq_num[7:0]};
      end else if (rd_d1) begin
        pipe_data <= fifo_q;
      end

      if (drain_done) seq_num <= seq_num + 16'd1;
    end
  end

  pipe_sticky_flag u_overflow (
    .clk   (FPGA_CLK),
    .rst_n (RST_N),
    .set   (fifo_full && enable),
    .clr   (clr_flags),
    .flag  (overflow)
  );

  pipe_sticky_flag u_underrun (
    .clk   (FPGA_CLK),
    .rst_n (RST_N),
    .set   ((state == BURST) && fifo_empty),
    .clr   (clr_flags),
    .flag  (underrun)
  );

endmodule

// File: tb/tb_pipe_block_scheduler.sv
// Directed testbench for pipe_block_scheduler (BLOCK_WORDS=4). Works with or
// without PIPE_FRAME_HDR_EN; H shifts expected timing by the header cycle.
module tb_pipe_block_scheduler;

`ifdef PIPE_FRAME_HDR_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic        FPGA_CLK;
  logic        RST_N;
  logic        enable;
  logic [11:0] fifo_rdcnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic [15:0] fifo_q;
  logic        fifo_re;
  logic        host_start;
  logic        clr_flags;
  logic        blk_ready;
  logic        busy;
  logic        pipe_valid;
  logic [15:0] pipe_data;
  logic        overflow;
  logic        underrun;
  logic [15:0] seq_num;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] word_q[$];
  int          wcyc_q[$];
  int          re_q[$];
  bit          busy_bad;
  logic [15:0] rd_ptr;

  pipe_block_scheduler #(.BLOCK_WORDS(4), .CNT_W(12)) dut (
    .FPGA_CLK   (FPGA_CLK),
    .RST_N      (RST_N),
    .enable     (enable),
    .fifo_rdcnt (fifo_rdcnt),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_q     (fifo_q),
    .fifo_re    (fifo_re),
    .host_start (host_start),
    .clr_flags  (clr_flags),
    .blk_ready  (blk_ready),
    .busy       (busy),
    .pipe_valid (pipe_valid),
    .pipe_data  (pipe_data),
    .overflow   (overflow),
    .underrun   (underrun),
    .seq_num    (seq_num)
  );

  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  // FIFO model: word n read returns n (1-based); pointer restarts on reset.
  always @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= 16'd0;
      fifo_q <= 16'd0;
    end else if (fifo_re) begin
      fifo_q <= rd_ptr + 16'd1;
      rd_ptr <= rd_ptr + 16'd1;
    end
  end

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge FPGA_CLK) begin
    if (pipe_valid) begin
      word_q.push_back(pipe_data);
      wcyc_q.push_back(cyc);
      if (!busy) busy_bad = 1'b1;
    end
    if (fifo_re) re_q.push_back(cyc);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge FPGA_CLK);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    word_q.delete();
    wcyc_q.delete();
    re_q.delete();
    busy_bad = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (blk_ready === 1'b1) ok = 1'b1;
      else cycle();
    end
  endtask

  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 60 && busy !== 1'b0; i++) cycle();
    ok = (busy === 1'b0);
  endtask

  task automatic start_block(output int s);
    s = cyc;
    host_start = 1'b1;
    cycle();
    host_start = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; enable = 1'b0; fifo_rdcnt = 12'd0; fifo_empty = 1'b0;
    fifo_full = 1'b0; host_start = 1'b0; clr_flags = 1'b0;
    repeat (3) cycle();
    total++;
    if ({fifo_re, blk_ready, busy, pipe_valid, overflow, underrun} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {fifo_re, blk_ready, busy, pipe_valid, overflow, underrun});
    end
    total++;
    if (pipe_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", pipe_data); end
    total++;
    if (seq_num !== 16'h0) begin bad++; $display("FAIL reset_seq: got %h want 0000", seq_num); end
    RST_N = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    int s; bit ok; logic [15:0] exp_w[$];
    enable = 1'b1; fifo_rdcnt = 12'd3;
    repeat (3) cycle();
    total++;
    if (blk_ready !== 1'b0) begin bad++; $display("FAIL basic_below_thresh: got %b want 0", blk_ready); end
    fifo_rdcnt = 12'd4;
    #1;
    total++;
    if (blk_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_early: got %b want 0", blk_ready); end
    cycle();
    total++;
    if (blk_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_rise: got %b want 1", blk_ready); end
    clear_log();
    start_block(s);
    total++;
    if (blk_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_drop: got %b want 0", blk_ready); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: busy got 1 want 0"); end
    if (H != 0) exp_w.push_back(16'hA500);
    for (int i = 1; i <= 4; i++) exp_w.push_back(16'(i));
    total++;
    if (word_q.size() != exp_w.size()) begin
      bad++; $display("FAIL basic_count: got %0d want %0d", word_q.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        total++;
        if (word_q[i] !== exp_w[i]) begin bad++; $display("FAIL basic_word%0d: got %h want %h", i, word_q[i], exp_w[i]); end
      end
      total++;
      if (wcyc_q[H] != s + 3 + H || wcyc_q[H+3] != s + 6 + H) begin
        bad++; $display("FAIL basic_word_timing: got %0d..%0d want %0d..%0d",
                        wcyc_q[H] - s, wcyc_q[H+3] - s, 3 + H, 6 + H);
      end
    end
    total++;
    if (re_q.size() != 4 || re_q[0] != s + 1 + H || re_q[3] != s + 4 + H) begin
      bad++; $display("FAIL basic_re: got %0d reads first@%0d want 4 reads first@%0d",
                      re_q.size(), (re_q.size() > 0) ? re_q[0] - s : -1, 1 + H);
    end
    total++;
    if (cyc != s + 7 + H) begin bad++; $display("FAIL basic_busy_end: got %0d want %0d", cyc - s, 7 + H); end
    total++;
    if (busy_bad) begin bad++; $display("FAIL basic_busy_cover: got pipe_valid outside busy want none"); end
    total++;
    if (seq_num !== 16'h0001) begin bad++; $display("FAIL basic_seq: got %h want 0001", seq_num); end
    total++;
    if (blk_ready !== 1'b0) begin bad++; $display("FAIL b2b_wait: got %b want 0", blk_ready); end
    cycle();
    total++;
    if (blk_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", blk_ready); end
  endtask

  task automatic test_underrun();
    int s; int r0; bit ok; logic [15:0] exp_w[$]; int exp_r[$];
    clear_log();
    start_block(s);
    r0 = s + 1 + H;
    repeat (H) cycle();
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_before: got %b want 0", underrun); end
    cycle(); cycle();
    fifo_empty = 1'b1;
    repeat (3) cycle();
    fifo_empty = 1'b0;
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set: got %b want 1", underrun); end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL underrun_timeout: busy got 1 want 0"); end
    exp_r = '{r0, r0 + 1, r0 + 5, r0 + 6};
    total++;
    if (re_q.size() != 4) begin
      bad++; $display("FAIL underrun_re_count: got %0d want 4", re_q.size());
    end else begin
      foreach (exp_r[i]) begin
        total++;
        if (re_q[i] != exp_r[i]) begin bad++; $display("FAIL underrun_re%0d: got %0d want %0d", i, re_q[i] - s, exp_r[i] - s); end
      end
    end
    if (H != 0) exp_w.push_back(16'hA501);
    for (int i = 5; i <= 8; i++) exp_w.push_back(16'(i));
    total++;
    if (word_q.size() != exp_w.size()) begin
      bad++; $display("FAIL underrun_count: got %0d want %0d", word_q.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        total++;
        if (word_q[i] !== exp_w[i]) begin bad++; $display("FAIL underrun_word%0d: got %h want %h", i, word_q[i], exp_w[i]); end
      end
      total++;
      if (wcyc_q[H+2] != r0 + 7) begin bad++; $display("FAIL underrun_gap: got %0d want %0d", wcyc_q[H+2] - s, r0 + 7 - s); end
    end
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
    total++;
    if (seq_num !== 16'h0002) begin bad++; $display("FAIL underrun_seq: got %h want 0002", seq_num); end
  endtask

  task automatic test_overflow();
    bit ok;
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL overflow_ready_timeout: blk_ready got 0 want 1"); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_before: got %b want 0", overflow); end
    fifo_full = 1'b1; cycle(); fifo_full = 1'b0;
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b want 1", overflow); end
    cycle();
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
    clr_flags = 1'b1; cycle(); clr_flags = 1'b0;
    total++;
    if ({overflow, underrun} !== 2'b00) begin bad++; $display("FAIL flags_clear: got %b want 00", {overflow, underrun}); end
    fifo_full = 1'b1; clr_flags = 1'b1; cycle(); fifo_full = 1'b0; clr_flags = 1'b0;
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set_wins: got %b want 1", overflow); end
    clr_flags = 1'b1; cycle(); clr_flags = 1'b0;
    enable = 1'b0; fifo_full = 1'b1; cycle(); fifo_full = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_disabled: got %b want 0", overflow); end
    total++;
    if (blk_ready !== 1'b0) begin bad++; $display("FAIL ready_enable_drop: got %b want 0", blk_ready); end
    enable = 1'b1;
  endtask

  task automatic test_enable_drop();
    int s; bit ok; logic [15:0] exp_w[$]; bit rdy_seen;
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL drop_ready_timeout: blk_ready got 0 want 1"); end
    clear_log();
    start_block(s);
    repeat (H + 2) cycle();
    enable = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL drop_timeout: busy got 1 want 0"); end
    if (H != 0) exp_w.push_back(16'hA502);
    for (int i = 9; i <= 12; i++) exp_w.push_back(16'(i));
    total++;
    if (word_q.size() != exp_w.size()) begin
      bad++; $display("FAIL drop_count: got %0d want %0d", word_q.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        total++;
        if (word_q[i] !== exp_w[i]) begin bad++; $display("FAIL drop_word%0d: got %h want %h", i, word_q[i], exp_w[i]); end
      end
    end
    total++;
    if (seq_num !== 16'h0003) begin bad++; $display("FAIL drop_seq: got %h want 0003", seq_num); end
    clear_log();
    rdy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (blk_ready !== 1'b0) rdy_seen = 1'b1;
      cycle();
    end
    total++;
    if (rdy_seen) begin bad++; $display("FAIL drop_idle_ready: got 1 want 0"); end
    host_start = 1'b1; cycle(); host_start = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL drop_start_ignored: busy got %b want 0", busy); end
    repeat (4) cycle();
    total++;
    if (re_q.size() != 0 || word_q.size() != 0) begin
      bad++; $display("FAIL drop_no_traffic: got %0d reads %0d words want 0 0", re_q.size(), word_q.size());
    end
    total++;
    if (seq_num !== 16'h0003) begin bad++; $display("FAIL drop_seq_hold: got %h want 0003", seq_num); end
  endtask

  task automatic test_reset_mid_burst();
    int s; bit ok;
    enable = 1'b1;
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_ready_timeout: blk_ready got 0 want 1"); end
    fifo_full = 1'b1; cycle(); fifo_full = 1'b0;
    start_block(s);
    cycle();
    RST_N = 1'b0;
    #1;
    total++;
    if ({fifo_re, blk_ready, busy, pipe_valid, overflow, underrun} !== 6'b0) begin
      bad++; $display("FAIL rst_mid_flags: got %b want 000000",
                      {fifo_re, blk_ready, busy, pipe_valid, overflow, underrun});
    end
    total++;
    if (pipe_data !== 16'h0) begin bad++; $display("FAIL rst_mid_data: got %h want 0000", pipe_data); end
    total++;
    if (seq_num !== 16'h0) begin bad++; $display("FAIL rst_mid_seq: got %h want 0000", seq_num); end
    cycle();
    RST_N = 1'b1;
    cycle();
    total++;
    if (blk_ready !== 1'b0) begin bad++; $display("FAIL rst_state_idle: blk_ready got %b want 0", blk_ready); end
    cycle();
    total++;
    if (blk_ready !== 1'b1) begin bad++; $display("FAIL rst_reacquire: blk_ready got %b want 1", blk_ready); end
  endtask

  task automatic test_seq_header();
    int s; bit ok; bit any_to; logic [15:0] exp_w[$];
    any_to = 1'b0;
    for (int n = 0; n < 258; n++) begin
      wait_ready(ok);
      if (!ok) any_to = 1'b1;
      start_block(s);
      wait_idle(ok);
      if (!ok) any_to = 1'b1;
    end
    total++;
    if (any_to) begin bad++; $display("FAIL seq_loop_timeout: got timeout want none"); end
    total++;
    if (seq_num !== 16'h0102) begin bad++; $display("FAIL seq_0102: got %h want 0102", seq_num); end
    wait_ready(ok);
    clear_log();
    start_block(s);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hdr_timeout: busy got 1 want 0"); end
    if (H != 0) exp_w.push_back(16'hA502);
    for (int i = 0; i < 4; i++) exp_w.push_back(16'h0409 + 16'(i));
    total++;
    if (word_q.size() != exp_w.size()) begin
      bad++; $display("FAIL hdr_count: got %0d want %0d", word_q.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        total++;
        if (word_q[i] !== exp_w[i]) begin bad++; $display("FAIL hdr_word%0d: got %h want %h", i, word_q[i], exp_w[i]); end
      end
      total++;
      if (wcyc_q[0] != s + 3 - H) begin bad++; $display("FAIL hdr_first_cycle: got %0d want %0d", wcyc_q[0] - s, 3 - H); end
    end
    total++;
    if (re_q.size() != 4 || re_q[0] != s + 1 + H) begin
      bad++; $display("FAIL hdr_re: got %0d reads want 4 first@%0d", re_q.size(), 1 + H);
    end
    total++;
    if (seq_num !== 16'h0103) begin bad++; $display("FAIL seq_0103: got %h want 0103", seq_num); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_overflow();
    test_enable_drop();
    test_reset_mid_burst();
    test_seq_header();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
